mc_main_control: RTL and testbench

MC_MAIN_CONTROL -- requirements
Module: mc_main_control

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_wait_timer.sv | 39 +++
 rtl/mc_main_control.sv | 186 ++++++++++++++++++
 tb/tb_mc_main_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle main control unit.
// Holds opcode values, the 4-bit state encoding, ALU-op classes and mux selects.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EX   = 4'd11,
        ST_ADDI_WB   = 4'd12
    } mc_state_e;

    // States that hold while memory has not yet completed the access.
    function automatic logic is_wait_state(mc_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: 8-bit saturating count of mem_ready-low cycles in a wait state.
// expired is high once the count has reached MEM_TIMEOUT.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear on entry to a wait state, otherwise count stalled cycles up to 255.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS-style main control FSM with memory-wait timeout.
// Optional macro MC_CTRL_ADDI_EN enables the ADDI_EX/ADDI_WB path for opcode 001000;
// without it that opcode decodes as illegal.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    mc_state_e  state_q;
    mc_state_e  state_d;
    logic [5:0] op_q;
    logic [5:0] op_d;
    logic       in_wait;
    logic       wait_expired;
    logic       wait_clear;
    logic       wait_enable;
    logic       timed_out;

    assign in_wait     = is_wait_state(state_q);
    assign wait_enable = in_wait && !mem_ready;
    assign timed_out   = in_wait && wait_expired && !mem_ready;
    // A timeout re-enters FETCH, so it restarts the count like any other entry.
    assign wait_clear  = is_wait_state(state_d) && ((state_d != state_q) || timed_out);
    assign state       = state_q;

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wait_expired)
    );

    // Next-state and datapath control decode from the current state.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_op        = ALU_ADD;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = SRCB_FOUR;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
                mem_timeout = timed_out;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SHL;
                op_d      = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                mem_read    = 1'b1;
                i_or_d      = 1'b1;
                mem_timeout = timed_out;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timed_out) begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_write   = 1'b1;
                i_or_d      = 1'b1;
                mem_timeout = timed_out;
                if (mem_ready || timed_out) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_OUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed pins plus randomized run against an instruction-recipe model.
module tb_mc_main_control;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic [3:0] state;
    ctrl_t      dut_vec;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    mc_state_e m_state;
    mc_state_e plan[$];
    int        m_cnt;

    always #5 clk = ~clk;

    mc_main_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state)
    );

    assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                      ir_write, reg_dst, reg_write, alu_src_a, alu_op, alu_src_b,
                      pc_source, illegal_op, mem_timeout, state};

    // Opcodes the decoder accepts in this build.
    function automatic logic isLegal(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ || op == OP_J) return 1'b1;
`ifdef MC_CTRL_ADDI_EN
        if (op == OP_ADDI) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Outputs each state must present, from the control table.
    function automatic ctrl_t expVec(input mc_state_e s, input logic mr, input logic [5:0] op, input int cnt);
        ctrl_t v;
        logic  tmo;
        v = '0;
        v.state = s;
        tmo = !mr && (cnt == TO);
        case (s)
            ST_FETCH: begin
                v.mem_read = 1'b1; v.alu_src_b = 2'b01;
                v.ir_write = mr; v.pc_write = mr; v.mem_timeout = tmo;
            end
            ST_DECODE:    begin v.alu_src_b = 2'b11; v.illegal_op = !isLegal(op); end
            ST_MEM_ADDR:  begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
            ST_MEM_READ:  begin v.mem_read = 1'b1; v.i_or_d = 1'b1; v.mem_timeout = tmo; end
            ST_MEM_WB:    begin v.mem_to_reg = 1'b1; v.reg_write = 1'b1; end
            ST_MEM_WRITE: begin v.mem_write = 1'b1; v.i_or_d = 1'b1; v.mem_timeout = tmo; end
            ST_EXECUTE:   begin v.alu_src_a = 1'b1; v.alu_op = 2'b10; end
            ST_R_WB:      begin v.reg_dst = 1'b1; v.reg_write = 1'b1; end
            ST_BRANCH: begin
                v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
            end
            ST_JUMP:      begin v.pc_write = 1'b1; v.pc_source = 2'b10; end
            ST_ADDI_EX:   begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
            ST_ADDI_WB:   begin v.reg_write = 1'b1; end
            default:      v.state = s;
        endcase
        return v;
    endfunction

    // Next step of the current instruction; an empty plan means fetch again.
    function automatic mc_state_e nextFromPlan();
        if (plan.size() == 0) return ST_FETCH;
        return plan.pop_front();
    endfunction

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic modelStep(input logic rst, input logic [5:0] op, input logic mr);
        mc_state_e nxt;
        if (rst) begin
            plan.delete();
            m_state = ST_IDLE;
            m_cnt   = 0;
        end else begin
            m_cnt = (m_cnt < 0) ? 0 : m_cnt;
            if (m_state == ST_FETCH || m_state == ST_MEM_READ || m_state == ST_MEM_WRITE) begin
                if (mr) begin
                    nxt   = (m_state == ST_FETCH) ? ST_DECODE : nextFromPlan();
                    m_cnt = 0;
                end else if (m_cnt == TO) begin
                    plan.delete();
                    nxt   = ST_FETCH;
                    m_cnt = 0;
                end else begin
                    nxt = m_state;
                    if (m_cnt < 255) m_cnt++;
                end
            end else begin
                if (m_state == ST_IDLE) begin
                    nxt = ST_FETCH;
                end else if (m_state == ST_DECODE) begin
                    plan.delete();
                    if (op == OP_LW) begin
                        plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_READ); plan.push_back(ST_MEM_WB);
                    end else if (op == OP_SW) begin
                        plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_WRITE);
                    end else if (op == OP_RTYPE) begin
                        plan.push_back(ST_EXECUTE); plan.push_back(ST_R_WB);
                    end else if (op == OP_BEQ) begin
                        plan.push_back(ST_BRANCH);
                    end else if (op == OP_J) begin
                        plan.push_back(ST_JUMP);
                    end else if (op == OP_ADDI && isLegal(op)) begin
                        plan.push_back(ST_ADDI_EX); plan.push_back(ST_ADDI_WB);
                    end
                    nxt = nextFromPlan();
                end else begin
                    nxt = nextFromPlan();
                end
                m_cnt = 0;
            end
            m_state = nxt;
        end
    endtask

    // Whole-vector comparison of the DUT against the model for this cycle.
    task automatic checkOutput();
        ctrl_t exp_v;
        exp_v = expVec(m_state, mem_ready, opcode, m_cnt);
        checks++;
        if (dut_vec !== exp_v) begin
            errors++;
            $display("[TB] FAIL ctrl cycle %0d: actual=%h required=%h", cycle, dut_vec, exp_v);
        end
    endtask

    // Hand-computed expectation that pins the model and DUT independently.
    task automatic checkPin(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: actual=%0h required=%0h", name, cycle, actual, required);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, check, then advance the model.
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic mr);
        @(negedge clk);
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        #1;
        cycle++;
        checkOutput();
        modelStep(rst, op, mr);
    endtask

    initial begin
        logic [5:0] op_tab [8];
        int         p;
        logic [5:0] rop;
        logic       rmr;
        logic       rrst;

        op_tab[0] = OP_LW;   op_tab[1] = OP_SW; op_tab[2] = OP_RTYPE; op_tab[3] = OP_BEQ;
        op_tab[4] = OP_J;    op_tab[5] = OP_ADDI; op_tab[6] = 6'h3F;  op_tab[7] = 6'h00;

        reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
        m_state = ST_IDLE; m_cnt = 0;
        repeat (2) @(posedge clk);

        applyStimulus(1'b1, 6'd0, 1'b1);
        checkPin("reset_outputs_zero", 32'(dut_vec), 32'd0);

        // lw with memory always ready
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_idle", 32'(state), 32'd0);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_fetch", 32'(state), 32'd1);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_decode", 32'(state), 32'd2);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_mem_addr", 32'(state), 32'd3);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_mem_read", 32'({state, reg_write}), 32'h8);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_mem_wb", 32'({state, reg_write, mem_to_reg}), 32'h17);
        applyStimulus(1'b0, OP_LW, 1'b1);  checkPin("lw_back_fetch", 32'(state), 32'd1);

        // R-type then beq
        applyStimulus(1'b0, OP_RTYPE, 1'b1);
        applyStimulus(1'b0, OP_RTYPE, 1'b1); checkPin("r_execute_aluop", 32'({state, alu_op}), 32'h1E);
        applyStimulus(1'b0, OP_RTYPE, 1'b1); checkPin("r_wb", 32'({state, reg_dst, reg_write}), 32'h23);
        applyStimulus(1'b0, OP_BEQ, 1'b1);
        applyStimulus(1'b0, OP_BEQ, 1'b1);
        applyStimulus(1'b0, OP_BEQ, 1'b1);
        checkPin("beq_branch", 32'({pc_write_cond, pc_source, alu_op}), 32'h15);

        // FETCH stalled three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, OP_SW, 1'b0);
            checkPin("fetch_stall_writes", 32'({ir_write, pc_write}), 32'd0);
        end
        applyStimulus(1'b0, OP_SW, 1'b1);
        checkPin("fetch_done_writes", 32'({ir_write, pc_write}), 32'd3);

        // sw whose memory never answers
        applyStimulus(1'b0, OP_SW, 1'b1); checkPin("sw_decode", 32'(state), 32'd2);
        applyStimulus(1'b0, OP_SW, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, OP_SW, 1'b0);
            checkPin("sw_wait_timeout", 32'({state, mem_timeout}), (i == 5) ? 32'hD : 32'hC);
        end
        applyStimulus(1'b0, OP_LW, 1'b1);
        checkPin("after_timeout_fetch", 32'({state, mem_write}), 32'h2);

        // reset in the middle of a read
        applyStimulus(1'b0, OP_LW, 1'b1);
        applyStimulus(1'b0, OP_LW, 1'b1);
        applyStimulus(1'b1, OP_LW, 1'b0); checkPin("reset_in_mem_read", 32'(state), 32'd4);
        applyStimulus(1'b0, OP_LW, 1'b0); checkPin("reset_idle_zero", 32'(dut_vec), 32'd0);
        applyStimulus(1'b0, OP_LW, 1'b1); checkPin("reset_then_fetch", 32'(state), 32'd1);

        // illegal opcodes
        applyStimulus(1'b0, 6'h3F, 1'b1); checkPin("illegal_3f", 32'(illegal_op), 32'd1);
        applyStimulus(1'b0, 6'h3F, 1'b1); checkPin("illegal_to_fetch", 32'(state), 32'd1);
        applyStimulus(1'b0, OP_ADDI, 1'b1);
`ifdef MC_CTRL_ADDI_EN
        checkPin("addi_decode", 32'(illegal_op), 32'd0);
        applyStimulus(1'b0, OP_ADDI, 1'b1); checkPin("addi_ex", 32'(state), 32'd11);
`else
        checkPin("addi_decode", 32'(illegal_op), 32'd1);
        applyStimulus(1'b0, OP_ADDI, 1'b1); checkPin("addi_to_fetch", 32'(state), 32'd1);
`endif

        // randomized run with shifting memory responsiveness
        p = 90;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       p = 90;
                    1:       p = 50;
                    default: p = 12;
                endcase
            end
            rop = op_tab[$urandom_range(0, 7)];
            if (rop == 6'h00 && $urandom_range(0, 3) == 0) rop = 6'($urandom);
            rmr  = ($urandom_range(0, 99) < p);
            rrst = ($urandom_range(0, 149) == 0);
            applyStimulus(rrst, rop, rmr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
